// File: rtl/frame_agm_pkg.sv
// Shared types for the frame address generator: scan modes, FSM states and
// the decoding of the external scan-mode select.
package frame_agm_pkg;

  typedef enum logic [1:0] {
    RASTER = 2'd0,
    HFLIP  = 2'd1,
    VFLIP  = 2'd2,
    ROT180 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Reserved codes 4..7 fall back to raster order.
  function automatic mode_t sel_to_mode(input logic [2:0] sel);
    mode_t m;
    case (sel)
      3'd1:    m = HFLIP;
      3'd2:    m = VFLIP;
      3'd3:    m = ROT180;
      default: m = RASTER;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth valid pipeline that turns read enables into write strobes.
// The tap feeding the last stage is exposed so the write address can be
// registered in the same cycle as the strobe.
module valid_delay #(
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  output logic o_vld,
  output logic o_vld_pre_c
);

  logic [PIPE_LAT-1:0] r_sr;
  logic [PIPE_LAT:0]   w_taps;

  assign w_taps      = {r_sr, i_vld};
  assign o_vld_pre_c = w_taps[PIPE_LAT-1];
  assign o_vld       = w_taps[PIPE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sr <= '0;
    else        r_sr <= w_taps[PIPE_LAT-1:0];
  end

endmodule

// File: rtl/frame_addr_gen.sv
// Frame read/write address generator: issues one frame of source reads in a
// selectable scan order and raster-order destination writes PIPE_LAT later.
module frame_addr_gen
  import frame_agm_pkg::*;
#(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [2:0]        sel,
  input  logic              pause,
  output logic              en_rd,
  output logic [ADDR_W-1:0] r_addr,
  output logic              wea,
  output logic [ADDR_W-1:0] w_addr,
  output logic              en_wr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N   = IMG_W * IMG_H;
  localparam int unsigned X_W = $clog2(IMG_W);
  localparam int unsigned Y_W = $clog2(IMG_H);

  localparam logic [X_W-1:0]    X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST = Y_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] XMAX_A = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] NM1_A  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] RROW0  = ADDR_W'((IMG_H - 1) * IMG_W);

  state_t              r_state, w_next;
  mode_t               r_mode;
  logic [X_W-1:0]      r_x;
  logic [Y_W-1:0]      r_y;
  logic [ADDR_W-1:0]   r_row;
  logic [ADDR_W-1:0]   r_rrow;
  logic [ADDR_W-1:0]   r_wcnt;
  logic [ADDR_W-1:0]   w_xa;
  logic [ADDR_W-1:0]   w_raddr;
  logic                w_issue_c;
  logic                w_wea_pre;
  logic                w_x_last;
  logic                w_y_last;

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);
  assign en_wr    = busy;

  // Row base counts up for forward rows; r_rrow counts down for v-flip.
  always_comb begin
    w_xa = ADDR_W'(r_x);
    case (r_mode)
      HFLIP:   w_raddr = r_row + (XMAX_A - w_xa);
      VFLIP:   w_raddr = r_rrow + w_xa;
      ROT180:  w_raddr = NM1_A - (r_row + w_xa);
      default: w_raddr = r_row + w_xa;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_issue_c = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = RUN;
      RUN: begin
        if (!pause) begin
          w_issue_c = 1'b1;
          if (w_x_last && w_y_last) w_next = DRAIN;
        end
      end
      // Leave once the final write strobe is being registered.
      DRAIN: if (w_wea_pre && (r_wcnt == NM1_A)) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_rd  <= 1'b0;
      r_addr <= '0;
      w_addr <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      r_mode <= RASTER;
      r_x    <= '0;
      r_y    <= '0;
      r_row  <= '0;
      r_rrow <= '0;
      r_wcnt <= '0;
    end else begin
      en_rd <= w_issue_c;
      busy  <= (r_state == RUN) || (r_state == DRAIN);
      done  <= (r_state == DONE);
      if ((r_state == IDLE) && start) begin
        r_mode <= sel_to_mode(sel);
        r_x    <= '0;
        r_y    <= '0;
        r_row  <= '0;
        r_rrow <= RROW0;
        r_wcnt <= '0;
      end else if (w_issue_c) begin
        r_addr <= w_raddr;
        if (w_x_last) begin
          r_x <= '0;
          if (!w_y_last) begin
            r_y    <= r_y + Y_W'(1);
            r_row  <= r_row + W_A;
            r_rrow <= r_rrow - W_A;
          end
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end
      if (w_wea_pre) begin
        w_addr <= r_wcnt;
        r_wcnt <= r_wcnt + ADDR_W'(1);
      end
    end
  end

  valid_delay #(.PIPE_LAT(PIPE_LAT)) u_valid_delay (
    .clk         (clk),
    .rst_n       (reset_n),
    .i_vld       (en_rd),
    .o_vld       (wea),
    .o_vld_pre_c (w_wea_pre)
  );

endmodule

// File: tb/tb_frame_addr_gen.sv
// Bench for frame_addr_gen: schedule-level reference model checked every
// cycle, directed frames pinned with literal sequences, then random traffic.
module tb_frame_addr_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int PL   = 2;
  localparam int AW   = 8;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [2:0]    sel;
  logic          pause;
  logic          en_rd;
  logic [AW-1:0] r_addr;
  logic          wea;
  logic [AW-1:0] w_addr;
  logic          en_wr;
  logic          busy;
  logic          done;

  frame_addr_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sel(sel), .pause(pause),
    .en_rd(en_rd), .r_addr(r_addr), .wea(wea), .w_addr(w_addr),
    .en_wr(en_wr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int lit [4][NPIX] = '{
    '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11},
    '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8},
    '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3},
    '{11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0}
  };

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Address a scan mode reads for the k-th pixel of the frame.
  function automatic int exp_addr(input int m, input int k);
    int x, y;
    x = k % W;
    y = k / W;
    case (m)
      1:       return y * W + (W - 1 - x);
      2:       return (H - 1 - y) * W + x;
      3:       return NPIX - 1 - (y * W + x);
      default: return y * W + x;
    endcase
  endfunction

  // Model state and DUT observations used by the directed checks.
  bit q[$];
  bit on = 0;
  int md = 0, k = 0, wr = 0;
  int e_rd = 0, e_ra = 0, e_we = 0, e_wa = 0, e_busy = 0, e_done = 0;
  int t_start = 0, t_done = -1, n_done = 0;
  int cap[$];

  initial begin
    for (int i = 0; i < PL; i++) q.push_back(1'b0);
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        on = 0; k = 0; wr = 0;
        e_rd = 0; e_ra = 0; e_we = 0; e_wa = 0; e_busy = 0; e_done = 0;
        q.delete();
        for (int i = 0; i < PL; i++) q.push_back(1'b0);
      end else begin
        e_we   = int'(q.pop_front());
        e_done = (on && wr == NPIX) ? 1 : 0;
        e_busy = (on && wr < NPIX) ? 1 : 0;
        e_rd   = 0;
        if (e_done != 0) begin
          on = 0;
        end else if (!on && start) begin
          on = 1; k = 0; wr = 0; t_start = cyc;
          md = (sel > 3'd3) ? 0 : int'(sel);
        end else if (on && k < NPIX && !pause) begin
          e_rd = 1;
          e_ra = exp_addr(md, k);
          k++;
        end
        q.push_back(e_rd != 0);
        if (e_we != 0) begin
          e_wa = wr;
          wr++;
        end
      end
      #1;
      chk("en_rd",  int'(en_rd),  e_rd);
      chk("r_addr", int'(r_addr), e_ra);
      chk("wea",    int'(wea),    e_we);
      chk("w_addr", int'(w_addr), e_wa);
      chk("busy",   int'(busy),   e_busy);
      chk("en_wr",  int'(en_wr),  e_busy);
      chk("done",   int'(done),   e_done);
      if (en_rd) cap.push_back(int'(r_addr));
      if (done) begin
        n_done++;
        t_done = cyc;
      end
    end
  end

  // One directed frame: start at edge 0, then per-edge overrides.
  task automatic frame(input logic [2:0] sl, input int p_lo, input int p_hi,
                       input int rs_at, input int st2_at,
                       input int sel_chg_at, input logic [2:0] sel2);
    @(negedge clk);
    cap.delete();
    n_done = 0;
    t_done = -1;
    start = 1'b1; sel = sl; pause = 1'b0; reset_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start   = (c == st2_at);
      if (c >= sel_chg_at) sel = sel2;
      pause   = (c >= p_lo && c <= p_hi);
      reset_n = !(c >= rs_at && c < rs_at + 2);
    end
  endtask

  task automatic chk_seq(input string nm, input int m);
    chk({nm, "_len"}, cap.size(), NPIX);
    for (int i = 0; i < NPIX; i++)
      if (i < cap.size()) chk(nm, cap[i], lit[m][i]);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; sel = 3'd0; pause = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(3'd0, 0, -1, 1000, 0, 1000, 3'd0);
    chk_seq("seq_raster", 0);
    chk("lat_raster", t_done - t_start, 15);
    chk("ndone_raster", n_done, 1);

    frame(3'd1, 0, -1, 1000, 0, 1000, 3'd1);
    chk_seq("seq_hflip", 1);
    frame(3'd2, 0, -1, 1000, 0, 1000, 3'd2);
    chk_seq("seq_vflip", 2);
    frame(3'd3, 0, -1, 1000, 0, 1000, 3'd3);
    chk_seq("seq_rot180", 3);
    frame(3'd5, 0, -1, 1000, 0, 1000, 3'd5);
    chk_seq("seq_sel5", 0);

    frame(3'd0, 5, 7, 1000, 0, 1000, 3'd0);
    chk_seq("seq_pause", 0);
    chk("lat_pause", t_done - t_start, 18);

    frame(3'd0, 0, -1, 1000, 6, 4, 3'd3);
    chk_seq("seq_restart", 0);
    chk("lat_restart", t_done - t_start, 15);
    chk("ndone_restart", n_done, 1);

    frame(3'd0, 0, -1, 7, 0, 1000, 3'd0);
    chk("ndone_reset", n_done, 0);
    frame(3'd0, 0, -1, 1000, 0, 1000, 3'd0);
    chk_seq("seq_after_reset", 0);
    chk("lat_after_reset", t_done - t_start, 15);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 7) == 0);
      sel     = 3'($urandom_range(0, 7));
      pause   = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    start = 1'b0; pause = 1'b0; reset_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_addr_gen.md
# frame_addr_gen

Parametrised BRAM address generator for the image-processing datapath. It sequences one full frame of read addresses from the source BRAM in one of four geometric scan orders, and the matching raster-order write addresses into the destination BRAM after a fixed pipeline latency. It replaces the fixed raster generator with configurable frame size, configurable pipeline latency, scan-order modes, pause gating and a start/busy/done handshake.

## Interface
Parameters:
- IMG_W, 256, pixels per row (>=2)
- IMG_H, 256, rows per frame (>=2)
- ADDR_W, 16, BRAM address width; 2^ADDR_W >= IMG_W*IMG_H
- PIPE_LAT, 2, cycles from a read issue to the corresponding processed pixel at the write port (>=1)

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to process one frame; sampled only in IDLE
- sel  in  3  scan mode: 0 raster, 1 h-flip, 2 v-flip, 3 rotate-180, 4..7 treated as 0; latched on the accepted start
- pause  in  1  when high, no read is issued this cycle
- en_rd  out  1  read enable: address on r_addr is valid
- r_addr  out  ADDR_W  source BRAM read address
- wea  out  1  write strobe to the destination BRAM
- w_addr  out  ADDR_W  destination BRAM write address
- en_wr  out  1  destination port enable; equals busy
- busy  out  1  high from the first RUN cycle until the last write
- done  out  1  one-cycle pulse after the last write

## Operation
- Let N = IMG_W*IMG_H. Column counter x runs 0..IMG_W-1; row counter y runs 0..IMG_H-1.
- The row base (y*IMG_W) is held in a register and updated by adding or subtracting IMG_W. The design contains no multiplier.
- Read address by mode:
  - mode 0: y*W+x
  - mode 1: y*W+(W-1-x)
  - mode 2: (H-1-y)*W+x
  - mode 3: N-1-(y*W+x)
- w_addr is always raster order: 0..N-1. It increments only on wea.
- Write latency is produced by a PIPE_LAT-deep valid shift register fed by en_rd. The shift register advances every cycle, including pause cycles, so a pause creates bubbles on wea.
- State machine:
  - IDLE -> RUN on start. In the same cycle, latch sel and clear the counters.
  - RUN: each cycle with pause=0, assert en_rd and advance x. When x wraps, advance y. After the read at x=W-1, y=H-1, go to DRAIN.
  - DRAIN: no reads. When the last wea has been issued, go to DONE.
  - DONE: assert done for one cycle, then go to IDLE.
- start while not in IDLE is ignored. Changes on sel after start are ignored.
- pause in IDLE, DRAIN or DONE has no effect.
- reset_n low at any time forces IDLE and clears all counters and the delay line. Any partly processed frame is abandoned.

## Timing
- Reset values: en_rd=0, r_addr=0, wea=0, w_addr=0, en_wr=0, busy=0, done=0.
- start is high at the edge of cycle 0. Then:
  - cycle 1: first en_rd, with the mode's first address, and busy=1.
  - cycle N: last read, assuming no pause.
  - cycle 1+PIPE_LAT: first wea, with w_addr=0.
  - cycle N+PIPE_LAT: last wea, with w_addr=N-1.
  - cycle N+PIPE_LAT+1: done=1 and busy=0.
- Each pause cycle during RUN delays every later event by one cycle.
- r_addr and w_addr are registered outputs. They hold their last value while their strobe is low.
- A new start may be accepted in the cycle after done.

## Structure
- Package frame_agm_pkg:
  - mode_t enum: RASTER, HFLIP, VFLIP, ROT180
  - state_t enum: IDLE, RUN, DRAIN, DONE
  - function sel_to_mode, mapping codes 4..7 to RASTER
- Sub-module valid_delay (parameter PIPE_LAT): a shift register with asynchronous active-low clear that produces wea from en_rd.
- Top level: FSM, x/y counters, row-base register, address mux, write counter.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, PIPE_LAT=2.
- sel=0, start -> r_addr sequence 0..11 on cycles 1..12; wea on cycles 3..14 with w_addr 0..11; done on cycle 15.
- sel=1 -> r_addr sequence 3,2,1,0,7,6,5,4,11,10,9,8. sel=2 -> r_addr sequence 8,9,10,11,4,5,6,7,0,1,2,3.
- sel=3 -> r_addr sequence 11 down to 0. sel=5 -> identical to sel=0.
- sel=0, pause high on cycles 5..7 -> en_rd low on those cycles, read address sequence unchanged; wea low on cycles 7..9; done on cycle 18.
- start pulsed again on cycle 6, and sel changed to 3 on cycle 4 -> no effect; the frame completes in raster order with a single done.
- reset_n low on cycle 7 -> all outputs 0 on the next sample; after release, a new start runs a full correct frame from address 0.
